// File: rtl/ddr3_pkg.sv
// Shared defaults and helpers for the DDR3 write-path packing blocks.
package ddr3_pkg;

  localparam int DDR3_DATA_WIDTH = 256;
  localparam int DDR3_ID_WIDTH   = 4;
  localparam int DDR3_IN_WIDTH   = 64;

  // Number of input lanes that make up one AXI write beat.
  function automatic int calc_ratio(input int data_w, input int in_w);
    return data_w / in_w;
  endfunction

  typedef logic [DDR3_DATA_WIDTH-1:0] beat_t;

endpackage

// File: rtl/ddr3_sync_fifo.sv
// Single-clock first-word-fall-through beat FIFO with occupancy output.
module ddr3_sync_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Fullness comes from the registered level, so a same-cycle pop never makes room for a push.
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ddr3_write_packer.sv
// Packs IN_WIDTH lanes into DATA_WIDTH beats for the DDR3 write engine, with flush/zero-pad.
// Define DDR3_PACK_LANE_REVERSE_EN to place lane 0 in the most significant slot.
module ddr3_write_packer
  import ddr3_pkg::*;
#(
  parameter int IN_WIDTH   = DDR3_IN_WIDTH,
  parameter int DATA_WIDTH = DDR3_DATA_WIDTH,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_vld,
  input  logic [IN_WIDTH-1:0]           s_dat,
  output logic                          s_rdy,
  input  logic                          flush,
  output logic                          dn_vld,
  output logic [DATA_WIDTH-1:0]         dn_dat,
  input  logic                          dn_rdy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic [31:0]                   beat_cnt,
  output logic                          busy
);

  localparam int         RATIO = calc_ratio(DATA_WIDTH, IN_WIDTH);
  localparam logic [3:0] LAST  = 4'(RATIO - 1);

  logic [3:0]            lane_cnt, lane_cnt_d, cnt_after, lane_pos;
  logic                  flush_pend, flush_pend_d;
  logic [DATA_WIDTH-1:0] pack_q, pack_d, beat_next, push_dat;
  logic                  accept, full_push, flush_push, push;
  logic                  full, empty;

  assign accept = s_vld & s_rdy;
  assign s_rdy  = ~flush_pend & ((lane_cnt != LAST) | ~full);
  assign dn_vld = ~empty;
  assign busy   = (lane_cnt != '0) | flush_pend | ~empty;

`ifdef DDR3_PACK_LANE_REVERSE_EN
  assign lane_pos = LAST - lane_cnt;
`else
  assign lane_pos = lane_cnt;
`endif

  // The pack register is cleared on every push, so unfilled lanes of a flushed beat are already zero.
  always_comb begin
    beat_next    = pack_q;
    cnt_after    = lane_cnt;
    flush_pend_d = flush_pend;
    if (accept) begin
      beat_next[int'(lane_pos)*IN_WIDTH +: IN_WIDTH] = s_dat;
      cnt_after = (lane_cnt == LAST) ? 4'd0 : lane_cnt + 4'd1;
    end
    full_push  = accept & (lane_cnt == LAST);
    flush_push = flush_pend & ~full;
    push       = full_push | flush_push;
    push_dat   = full_push ? beat_next : pack_q;
    pack_d     = push ? '0 : beat_next;
    lane_cnt_d = flush_push ? 4'd0 : cnt_after;
    if (flush_push)
      flush_pend_d = 1'b0;
    else if (flush && !flush_pend && cnt_after != 4'd0)
      flush_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt   <= '0;
      flush_pend <= 1'b0;
      pack_q     <= '0;
      beat_cnt   <= '0;
    end else begin
      lane_cnt   <= lane_cnt_d;
      flush_pend <= flush_pend_d;
      pack_q     <= pack_d;
      if (push) beat_cnt <= beat_cnt + 32'd1;
    end
  end

  ddr3_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (dn_rdy),
    .head     (dn_dat),
    .empty    (empty),
    .full     (full),
    .level    (level)
  );

endmodule
